// File: rtl/sync_fifo_stream_reader.sv
// rtl/sync_fifo_stream_reader.sv - FIFO read port to valid/ready stream through a 2-entry skid buffer
module sync_fifo_stream_reader #(
   parameter int Data_Width  = 8,
   parameter int Count_Width = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   fifo_empty,
   input  logic [Data_Width-1:0]  fifo_data,
   output logic                   fifo_r_en,
   output logic [Data_Width-1:0]  m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [Count_Width-1:0] word_count,
   output logic                   idle
);

   logic [1:0]            occ;
   logic                  inflight;
   logic [Data_Width-1:0] buf0;
   logic [Data_Width-1:0] buf1;

   logic                  pop_out;
   logic [1:0]            occ_after_pop;
   logic [2:0]            committed;
   logic [1:0]            occ_next;

   // Words already owned by this stage (buffered or returning from the FIFO)
   // after this cycle's handshake; a new pop is only allowed while one slot stays free.
   always_comb begin
      pop_out       = m_valid && m_ready;
      occ_after_pop = occ - {1'b0, pop_out};
      committed     = {1'b0, occ_after_pop} + {2'b00, inflight};
      fifo_r_en     = !rst && en && !fifo_empty && (committed < 3'd2);
      occ_next      = occ_after_pop + {1'b0, inflight};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ        <= 2'd0;
         inflight   <= 1'b0;
         buf0       <= '0;
         buf1       <= '0;
         m_valid    <= 1'b0;
         word_count <= '0;
      end else begin
         occ      <= occ_next;
         inflight <= fifo_r_en;
         m_valid  <= (occ_next != 2'd0);
         if (pop_out) begin
            word_count <= word_count + Count_Width'(1);
            buf0       <= buf1;
         end
         // The returning word lands in the first slot left free after the shift.
         if (inflight) begin
            if (occ_after_pop == 2'd0) begin
               buf0 <= fifo_data;
            end else begin
               buf1 <= fifo_data;
            end
         end
      end
   end

   assign m_data = buf0;
   assign idle   = (occ == 2'd0) && !inflight;

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// tb/tb_sync_fifo_stream_reader.sv - self-checking bench for sync_fifo_stream_reader
module tb_sync_fifo_stream_reader;
   localparam int DW   = 8;
   localparam int CW   = 4;
   localparam int LOGN = 32768;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_r_en;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [CW-1:0] word_count;
   logic          idle;

   always #5 clk = ~clk;

   sync_fifo_stream_reader #(.Data_Width(DW), .Count_Width(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_r_en(fifo_r_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .word_count(word_count), .idle(idle)
   );

   typedef struct {
      logic [DW-1:0] w;
      int            t;
   } ent_t;

   int            n_checks = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            exp_cnt = 0;
   bit            chk_on = 0;
   logic          r_sampled = 1'b0;
   logic [DW-1:0] fifo_q[$];
   ent_t          exp_q[$];
   logic [DW-1:0] got_q[$];
   logic          r_log[LOGN];
   logic          v_log[LOGN];
   logic          hs_log[LOGN];
   logic [DW-1:0] d_log[LOGN];
   int s_r, s_v, s_hs, f_r, l_r, f_hs, l_hs;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference: every popped word is owed to the stream two cycles after its pop, in pop order.
   task automatic compare_cycle();
      logic exp_valid, exp_pop, exp_r;
      int   owed;
      cyc++;
      if (chk_on) begin
         exp_valid = (exp_q.size() > 0) && (exp_q[0].t <= cyc);
         chk("m_valid", m_valid, exp_valid);
         if (exp_valid) chk("m_data", m_data, exp_q[0].w);
         chk("word_count", word_count, exp_cnt % (1 << CW));
         chk("idle", idle, exp_q.size() == 0);
         exp_pop = exp_valid && m_ready;
         owed    = exp_q.size() - int'(exp_pop);
         exp_r   = !rst && en && !fifo_empty && (owed < 2);
         chk("fifo_r_en", fifo_r_en, exp_r);
         chk("occ+inflight<=2", (int'(dut.occ) + int'(dut.inflight)) <= 2, 1);
         if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
         end else begin
            if (exp_pop) begin
               void'(exp_q.pop_front());
               exp_cnt++;
            end
            if (exp_r && fifo_q.size() > 0) exp_q.push_back('{w: fifo_q[0], t: cyc + 2});
         end
      end
      r_sampled = fifo_r_en;
      if (cyc < LOGN) begin
         r_log[cyc]  = fifo_r_en;
         v_log[cyc]  = m_valid;
         hs_log[cyc] = m_valid && m_ready;
         d_log[cyc]  = m_data;
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_cycle();
      @(posedge clk);
      #1;
      if (r_sampled && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      else fifo_data = DW'($urandom);
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push_seq(input int first, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(DW'(first + i));
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fifo_q.delete();
      fifo_empty = 1'b1;
      run(2);
      rst = 1'b0;
   endtask

   task automatic scan(input int from, input int to);
      s_r = 0; s_v = 0; s_hs = 0; f_r = -1; l_r = -1; f_hs = -1; l_hs = -1;
      got_q.delete();
      for (int i = from; i <= to && i < LOGN; i++) begin
         if (r_log[i]) begin s_r++; if (f_r < 0) f_r = i; l_r = i; end
         if (v_log[i]) s_v++;
         if (hs_log[i]) begin
            s_hs++; if (f_hs < 0) f_hs = i; l_hs = i;
            got_q.push_back(d_log[i]);
         end
      end
   endtask

   task automatic check_order(input string nm, input int n);
      for (int i = 0; i < n; i++)
         chk(nm, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(DW'(i + 1)));
   endtask

   initial begin
      int start, pushed, guard, errs;

      // Reset held two cycles with a word waiting and en high: no pop may leak out.
      en = 1'b1;
      fifo_q.push_back(8'h5A);
      fifo_empty = 1'b0;
      step();
      chk("r_en during reset 1", r_log[cyc], 1'b0);
      step();
      chk("r_en during reset 2", r_log[cyc], 1'b0);
      rst = 1'b0;
      en = 1'b0;
      chk_on = 1;
      chk("reset m_valid", m_valid, 1'b0);
      chk("reset m_data", m_data, 8'h00);
      chk("reset word_count", word_count, 4'd0);
      chk("reset idle", idle, 1'b1);
      fifo_q.delete();
      fifo_empty = 1'b1;
      en = 1'b1;
      run(2);

      // Single word
      m_ready = 1'b1;
      start = cyc + 1;
      push_seq(8'hA5, 1);
      run(8);
      scan(start, cyc);
      chk("single pops", s_r, 1);
      chk("single valid cycles", s_v, 1);
      chk("single pop-to-valid", l_hs - f_r, 2);
      chk("single data", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'hA5);
      chk("single word_count", word_count, 4'd1);
      chk("single idle", idle, 1'b1);

      // Streaming at full rate
      do_reset();
      start = cyc + 1;
      push_seq(1, 7);
      run(12);
      scan(start, cyc);
      chk("stream pops", s_r, 7);
      chk("stream pop span", l_r - f_r, 6);
      chk("stream valid cycles", s_v, 7);
      chk("stream handshake span", l_hs - f_hs, 6);
      check_order("stream order", 7);
      chk("stream word_count", word_count, 4'd7);

      // Backpressure
      do_reset();
      m_ready = 1'b0;
      start = cyc + 1;
      push_seq(1, 7);
      run(6);
      scan(start, cyc);
      chk("stall pops", s_r, 2);
      chk("stall handshakes", s_hs, 0);
      chk("stall valid cycles", s_v, 4);
      errs = 0;
      for (int i = start; i <= cyc; i++) if (v_log[i] && d_log[i] !== 8'h01) errs++;
      chk("stall data held", errs, 0);
      m_ready = 1'b1;
      run(12);
      scan(start, cyc);
      chk("release pops", s_r, 7);
      chk("release handshakes", s_hs, 7);
      chk("release no gaps", l_hs - f_hs, 6);
      check_order("release order", 7);
      chk("release word_count", word_count, 4'd7);

      // en gating after the third pop
      do_reset();
      start = cyc + 1;
      push_seq(1, 7);
      s_r = 0;
      for (int k = 0; k < 30 && s_r < 3; k++) begin
         step();
         scan(start, cyc);
      end
      chk("gate third pop reached", s_r, 3);
      en = 1'b0;
      run(8);
      scan(start, cyc);
      chk("gate pops", s_r, 3);
      chk("gate delivered", s_hs, 3);
      chk("gate last word", (got_q.size() > 0) ? 32'(got_q[got_q.size()-1]) : 32'hDEAD, 32'h03);
      chk("gate fifo left", fifo_q.size(), 4);
      chk("gate idle", idle, 1'b1);
      en = 1'b1;
      run(12);
      scan(start, cyc);
      chk("regate delivered", s_hs, 7);
      check_order("regate order", 7);
      chk("regate word_count", word_count, 4'd7);

      // Random ready, bursty fill, 1000 words
      do_reset();
      start = cyc + 1;
      pushed = 0;
      guard = 0;
      while (exp_cnt < 1000 && guard < 20000) begin
         if (pushed < 1000 && ($urandom % 4) == 0) begin
            int b;
            b = 1 + int'($urandom % 8);
            for (int i = 0; i < b && pushed < 1000; i++) begin
               fifo_q.push_back(DW'(pushed));
               pushed++;
            end
            fifo_empty = (fifo_q.size() == 0);
         end
         m_ready = $urandom % 2;
         step();
         guard++;
      end
      chk("random finished in budget", exp_cnt, 1000);
      m_ready = 1'b0;
      step();
      scan(start, cyc);
      chk("random handshakes", s_hs, 1000);
      errs = 0;
      for (int i = 0; i < 1000; i++)
         if (i >= got_q.size() || got_q[i] !== DW'(i)) errs++;
      chk("random order errors", errs, 0);
      chk("random word_count wrap", word_count, 4'd8);

      // Reset with words buffered and in flight
      m_ready = 1'b1;
      push_seq(8'h80, 10);
      run(4);
      rst = 1'b1;
      fifo_q.delete();
      fifo_empty = 1'b1;
      step();
      rst = 1'b0;
      chk("midreset m_valid", m_valid, 1'b0);
      chk("midreset m_data", m_data, 8'h00);
      chk("midreset word_count", word_count, 4'd0);
      chk("midreset idle", idle, 1'b1);
      run(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/sync_fifo_stream_reader.md
# sync_fifo_stream_reader

Downstream read-side stage for the synchronous FIFO. It pops words from the FIFO's one-cycle-latency read port (`r_en`/`empty`/`data_out`) and presents them on a valid/ready stream. A 2-entry skid buffer absorbs the FIFO read latency, so the stage sustains one word per cycle under continuous `m_ready` and never loses or duplicates a word under backpressure. The FIFO-side ports connect straight to the FIFO's read port; the stream side feeds any valid/ready consumer.

## Interface
- `Data_Width`, default 8: word width; must match the FIFO's `Data_Width`.
- `Count_Width`, default 16: width of `word_count`.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: when high, the stage may issue new FIFO pops.
- `fifo_empty`  in  1: FIFO `empty`.
- `fifo_data`  in  `Data_Width`: FIFO `data_out`; valid the cycle after an accepted pop.
- `fifo_r_en`  out  1: FIFO `r_en` (combinational).
- `m_data`  out  `Data_Width`: stream data, registered.
- `m_valid`  out  1: stream valid, registered.
- `m_ready`  in  1: stream ready from the consumer.
- `word_count`  out  `Count_Width`: number of stream handshakes completed, wrapping.
- `idle`  out  1: high when the buffer is empty and no pop is in flight.

## Operation
- Internal state:
  - `occ` (0..2): skid-buffer occupancy.
  - `inflight` (0/1): registered copy of `fifo_r_en`.
  - Buffer entries `buf0` (head) and `buf1`.
- Pop issue: `fifo_r_en = !rst && en && !fifo_empty && (occ + inflight - pop_out) < 2`, where `pop_out = m_valid && m_ready`.
  - A pop is asserted only when the FIFO is non-empty, so every asserted `fifo_r_en` is an accepted FIFO read.
- Capture: when `inflight` = 1, `fifo_data` is written into the buffer this cycle.
  - It goes into the first free slot after accounting for a same-cycle `pop_out`.
  - If `occ` = 1 and `pop_out`, the captured word becomes the new head.
- Output:
  - `m_valid = (occ != 0)`; `m_data = buf0`.
  - On `pop_out`, `buf1` shifts to `buf0`.
  - `m_data` and `m_valid` are held stable while `m_valid && !m_ready`.
- Ordering: the stream emits words in exact FIFO pop order. No drop, no duplicate.
- `fifo_data` is ignored whenever `inflight` = 0, even though the FIFO holds its last value.
- `en` low: no new pops. An in-flight word is still captured and the buffer keeps draining.
- `word_count` increments by 1 on each `pop_out`, modulo 2^`Count_Width` (all-ones wraps to 0).
- `idle = (occ == 0) && (inflight == 0)`.
- Invariant: `occ + inflight <= 2` at every edge. Overflowing the buffer is a design error.

## Timing
- Reset values (cycle after `rst` sampled high): `m_valid`=0, `m_data`=0, `occ`=0, `inflight`=0, `word_count`=0, `idle`=1.
  - `fifo_r_en` is 0 during any cycle where `rst`=1.
- Reset mid-operation discards buffered and in-flight words. Reset the FIFO together with this stage.
- First-word latency:
  - `fifo_empty` low in cycle N (with `en`=1, `idle`) → `fifo_r_en`=1 in cycle N.
  - `fifo_data` is valid in N+1 and captured at the end of N+1.
  - `m_valid`=1 in N+2.
- Throughput: 1 word/cycle with `m_ready` held high and the FIFO non-empty. Steady state is `occ`=1, `inflight`=1, with `fifo_r_en` high every cycle.
- Backpressure: with `m_ready`=0, at most 2 pops are issued. `fifo_r_en` then stays 0 until a `pop_out` occurs.
- Restart after backpressure: when `m_ready` rises with `occ`=2, the pop is issued in the same cycle as the first `pop_out`. No bubble beyond the FIFO latency.
- Simultaneous capture and `pop_out` with `occ`=2 cannot occur, by the issue rule.

## Test plan
- Reset: assert `rst` for 2 cycles with `fifo_empty`=0 and `en`=1.
  - Required: `fifo_r_en`=0 throughout, then `m_valid`=0, `m_data`=0, `word_count`=0, `idle`=1.
- Single word: FIFO holds 0xA5, `m_ready`=1.
  - Required: `fifo_r_en` pulses 1 cycle, `m_valid` is high exactly 1 cycle, 2 cycles after the pop, with `m_data`=0xA5; `word_count`=1; `idle` returns to 1.
- Streaming: FIFO pre-filled 0x01..0x07, `m_ready`=1.
  - Required: `fifo_r_en` high 7 consecutive cycles, `m_valid` high 7 consecutive cycles with `m_data` 0x01..0x07 in order, `word_count`=7.
- Backpressure: 7 words, `m_ready`=0 for 6 cycles, then 1.
  - Required: exactly 2 pops, then none; `m_data`=0x01 held stable; after release, all 7 words arrive in order with no gaps after the first; `word_count`=7.
- `en` gating: deassert `en` right after the 3rd pop with 7 words queued.
  - Required: in-flight word delivered; stream stops at 0x03; FIFO keeps 4 words.
  - Re-assert `en`: 0x04..0x07 follow.
- Random `m_ready` (50%) and bursty FIFO fill, 1000 words, then `rst` mid-stream.
  - Required: scoreboard matches order; `occ`+`inflight`≤2 always; `word_count` wraps correctly with `Count_Width`=4; all outputs reset the cycle after `rst`.
